// File: rtl/uart_prog_loader.sv
// Purpose: receive a framed program image over 8N1 UART and write it into CPU instruction memory.
// Latency: mem_we one cycle after the 4th byte of a word is received; cpu_rst_n/done two cycles after the CHK byte.
// Backpressure: none; the serial line cannot be stalled, and every write is a single-cycle strobe.
`timescale 1ns/1ps
module uart_prog_loader #(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_W       = 8,
   parameter int TIMEOUT_CYC  = 10_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              uart_rx,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_rst_n,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int              CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam int              TMO_W     = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [7:0]      SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [2:0] {L_IDLE, L_CNT, L_DATA, L_CHK, L_DONE, L_ERR} ld_state_t;

   // ---------------- receiver ----------------
   logic             rx_s1, rx_s2, rx_prev;
   rx_state_t        rx_state;
   logic [CNT_W-1:0] clk_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       rx_shift;
   logic             rx_valid;
   logic             rx_ferr;

   // Two-flop synchronizer plus one history flop for falling-edge detection.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= uart_rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   // Bit-timing state machine: start on a true falling edge, sample at bit centres.
   // Requiring an edge (not just a low level) keeps the tail of a bad stop bit
   // from being mistaken for a new start bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_state <= R_IDLE;
         clk_cnt  <= '0;
         bit_idx  <= '0;
         rx_shift <= '0;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
         case (rx_state)
            R_IDLE: begin
               clk_cnt <= '0;
               bit_idx <= '0;
               if (rx_prev && !rx_s2) rx_state <= R_START;
            end
            R_START: begin
               if (clk_cnt == HALF_LAST) begin
                  clk_cnt  <= '0;
                  rx_state <= rx_s2 ? R_IDLE : R_DATA;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            R_DATA: begin
               if (clk_cnt == BIT_LAST) begin
                  clk_cnt  <= '0;
                  rx_shift <= {rx_s2, rx_shift[7:1]};
                  bit_idx  <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) rx_state <= R_STOP;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            R_STOP: begin
               if (clk_cnt == BIT_LAST) begin
                  clk_cnt  <= '0;
                  rx_state <= R_IDLE;
                  if (rx_s2) rx_valid <= 1'b1;
                  else       rx_ferr  <= 1'b1;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            default: rx_state <= R_IDLE;
         endcase
      end
   end

   // ---------------- loader ----------------
   ld_state_t        ld_state;
   logic [8:0]       words_left;
   logic [1:0]       byte_idx;
   logic [23:0]      word_sr;
   logic [7:0]       chk_xor;
   logic [ADDR_W-1:0] wr_addr;
   logic [TMO_W-1:0] tmo_cnt;

   // Frame parser with registered outputs; an N byte of 0 means 256 words.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ld_state   <= L_IDLE;
         words_left <= '0;
         byte_idx   <= '0;
         word_sr    <= '0;
         chk_xor    <= '0;
         wr_addr    <= '0;
         tmo_cnt    <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cpu_rst_n  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         case (ld_state)
            L_IDLE: begin
               if (rx_valid && rx_shift == SYNC_BYTE) begin
                  ld_state  <= L_CNT;
                  busy      <= 1'b1;
                  cpu_rst_n <= 1'b0;
                  done      <= 1'b0;
                  err       <= 1'b0;
                  wr_addr   <= '0;
                  chk_xor   <= '0;
                  tmo_cnt   <= '0;
               end
            end
            L_CNT, L_DATA, L_CHK: begin
               if (rx_valid) begin
                  tmo_cnt <= '0;
                  chk_xor <= chk_xor ^ rx_shift;
                  if (ld_state == L_CNT) begin
                     words_left <= (rx_shift == 8'h00) ? 9'd256 : {1'b0, rx_shift};
                     byte_idx   <= '0;
                     ld_state   <= L_DATA;
                  end else if (ld_state == L_DATA) begin
                     word_sr  <= {word_sr[15:0], rx_shift};
                     byte_idx <= byte_idx + 2'd1;
                     if (byte_idx == 2'd3) begin
                        mem_we     <= 1'b1;
                        mem_addr   <= wr_addr;
                        mem_wdata  <= {word_sr, rx_shift};
                        wr_addr    <= wr_addr + 1'b1;
                        words_left <= words_left - 9'd1;
                        if (words_left == 9'd1) ld_state <= L_CHK;
                     end
                  end else begin
                     ld_state <= (rx_shift == chk_xor) ? L_DONE : L_ERR;
                  end
               end else if (rx_ferr || tmo_cnt == TMO_LAST) begin
                  ld_state <= L_ERR;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            L_DONE: begin
               done      <= 1'b1;
               busy      <= 1'b0;
               cpu_rst_n <= 1'b1;
               ld_state  <= L_IDLE;
            end
            L_ERR: begin
               err      <= 1'b1;
               busy     <= 1'b0;
               ld_state <= L_IDLE;
            end
            default: ld_state <= L_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Purpose: scoreboard bench for uart_prog_loader; stimulus pushes expected writes and end-of-frame status.
// Latency: monitor compares on the falling clock edge whenever mem_we is high or busy drops.
// Backpressure: not applicable; the bench drives the serial line at a fixed bit rate.
`timescale 1ns/1ps
module tb_uart_prog_loader;
   localparam int CPB = 8;
   localparam int AW  = 4;
   localparam int TMO = 400;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          uart_rx = 1'b1;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          cpu_rst_n, busy, done, err;

   uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
   typedef struct packed { logic done; logic err; logic cpu_rst_n; } st_t;

   wr_t        wq[$];
   st_t        sq[$];
   wr_t        we_exp;
   st_t        st_exp;
   logic [7:0] fb[$];
   int         checks = 0;
   int         errors = 0;
   logic       prev_busy = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every write and every end of frame is matched against the queues.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
         end else begin
            we_exp = wq.pop_front();
            chk("write_addr", 32'(mem_addr), 32'(we_exp.addr));
            chk("write_data", mem_wdata, we_exp.data);
         end
      end
      if (prev_busy === 1'b1 && busy === 1'b0) begin
         if (sq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame_end: got done %b err %b expected no frame end", done, err);
         end else begin
            st_exp = sq.pop_front();
            chk("end_done", 32'(done), 32'(st_exp.done));
            chk("end_err", 32'(err), 32'(st_exp.err));
            chk("end_cpu_rst_n", 32'(cpu_rst_n), 32'(st_exp.cpu_rst_n));
         end
      end
      prev_busy = busy;
   end

   task automatic bit_time();
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      uart_rx = 1'b0;
      bit_time();
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         bit_time();
      end
      uart_rx = stop_bit;
      bit_time();
      uart_rx = 1'b1;
   endtask

   task automatic send_fb();
      for (int i = 0; i < fb.size(); i++) send_byte(fb[i], 1'b1);
   endtask

   task automatic push_wr(input int a, input logic [31:0] d);
      wr_t w;
      w.addr = AW'(a);
      w.data = d;
      wq.push_back(w);
   endtask

   task automatic push_st(input logic d, input logic e, input logic c);
      st_t s;
      s.done = d;
      s.err = e;
      s.cpu_rst_n = c;
      sq.push_back(s);
   endtask

   task automatic wait_drain(input int max_cyc, input string name);
      int n = 0;
      while ((wq.size() != 0 || sq.size() != 0) && n < max_cyc) begin
         @(posedge clk);
         n++;
      end
      #1;
      checks++;
      if (wq.size() != 0 || sq.size() != 0) begin
         errors++;
         $display("FAIL %s: got %0d writes and %0d frame ends pending, expected 0 and 0", name, wq.size(), sq.size());
         wq.delete();
         sq.delete();
      end
   endtask

   // Word i of the N=0 image: bytes i, ~i, 5A, i^3C (MSB first).
   function automatic logic [31:0] big_word(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {b, ~b, 8'h5A, b ^ 8'h3C};
   endfunction

   task automatic send_big_word(input int i);
      logic [31:0] w;
      w = big_word(i);
      send_byte(w[31:24], 1'b1);
      send_byte(w[23:16], 1'b1);
      send_byte(w[15:8], 1'b1);
      send_byte(w[7:0], 1'b1);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got simulation still running expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset
      rst_n = 1'b0;
      uart_rx = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Two-word load; CHK = 02^28^01^28^02 = 01
      push_wr(0, 32'h2800_0001);
      push_wr(1, 32'h2800_0002);
      push_st(1'b1, 1'b0, 1'b1);
      send_byte(8'hA5, 1'b1);
      chk("sync_busy", 32'(busy), 32'd1);
      chk("sync_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      fb = '{8'h02, 8'h28, 8'h00, 8'h00, 8'h01, 8'h28, 8'h00, 8'h00, 8'h02, 8'h01};
      send_fb();
      wait_drain(50, "two_word_load");

      // Bad checksum, then the correct frame
      fb = '{8'hA5, 8'h02, 8'h28, 8'h00, 8'h00, 8'h01, 8'h28, 8'h00, 8'h00, 8'h02, 8'h00};
      push_wr(0, 32'h2800_0001);
      push_wr(1, 32'h2800_0002);
      push_st(1'b0, 1'b1, 1'b0);
      send_fb();
      wait_drain(50, "bad_checksum");
      fb[10] = 8'h01;
      push_wr(0, 32'h2800_0001);
      push_wr(1, 32'h2800_0002);
      push_st(1'b1, 1'b0, 1'b1);
      send_fb();
      wait_drain(50, "reload_after_bad");

      // Timeout mid-word, then a stray 00 in IDLE
      fb = '{8'hA5, 8'h01, 8'h28, 8'h00};
      push_st(1'b0, 1'b1, 1'b0);
      send_fb();
      wait_drain(600, "timeout");
      repeat (100) @(posedge clk);
      #1;
      send_byte(8'h00, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      chk("idle_byte_busy", 32'(busy), 32'd0);
      chk("idle_byte_err", 32'(err), 32'd1);
      chk("idle_byte_cpu_rst_n", 32'(cpu_rst_n), 32'd0);

      // Glitch in IDLE must not eat the following frame; CHK = 01^11^22^33^44 = 45
      uart_rx = 1'b0;
      repeat (2) @(posedge clk);
      #1 uart_rx = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("glitch_busy", 32'(busy), 32'd0);
      fb = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
      push_wr(0, 32'h1122_3344);
      push_st(1'b1, 1'b0, 1'b1);
      send_fb();
      wait_drain(50, "after_glitch");

      // Framing error after sync byte
      push_st(1'b0, 1'b1, 1'b0);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h28, 1'b0);
      wait_drain(50, "framing_error");

      // N=0: 256 words, address wraps every 16; each word XORs to 99^i, so CHK = 00
      for (int i = 0; i < 256; i++) push_wr(i % 16, big_word(i));
      push_st(1'b1, 1'b0, 1'b1);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      for (int i = 0; i < 256; i++) send_big_word(i);
      send_byte(8'h00, 1'b1);
      wait_drain(50, "n0_wrap");

      // Same frame, reset after the 10th word
      for (int i = 0; i < 10; i++) push_wr(i, big_word(i));
      push_st(1'b0, 1'b0, 1'b1);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      for (int i = 0; i < 10; i++) send_big_word(i);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      wait_drain(10, "reset_mid_frame");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Runtime program loader for the MIPS core's instruction memory. It receives a framed image over a UART line on one `EXT_IO` pin and writes 32-bit words into the CPU memory write port. It holds the CPU in reset while loading and releases it when the frame's checksum verifies. It sits in the board top beside `mips_cpu` and `vga_char`, and replaces simulation-only memory preloading with a loader that also works on hardware.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200).
- `ADDR_W`, 8: memory word-address width.
- `TIMEOUT_CYC`, 10_000_000: maximum idle cycles between bytes inside a frame.
- `clk`  in  1  system clock; only clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `uart_rx`  in  1  asynchronous serial input, 8N1, idle high.
- `mem_we`  out  1  one-cycle write strobe to CPU memory.
- `mem_addr`  out  ADDR_W  word address for `mem_we`.
- `mem_wdata`  out  32  word data for `mem_we`.
- `cpu_rst_n`  out  1  active-low reset to `mips_cpu`.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  sticky; last frame loaded and verified.
- `err`  out  1  sticky; last frame aborted.

## Operation
- **Receiver**
  - `uart_rx` passes through a 2-FF synchronizer.
  - A falling edge in the idle state starts a bit counter. The start bit is re-checked low at `CLKS_PER_BIT/2`; if it is high, the edge is a glitch and the receiver returns to idle.
  - The 8 data bits are sampled LSB-first at each subsequent bit centre.
  - The stop bit is sampled at its centre:
    - Stop bit = 1: pulse `rx_valid` for 1 cycle with the byte.
    - Stop bit = 0: pulse `rx_ferr` instead.
- **Frame format:** `0xA5`, then N (1 byte; 0 means 256), then N words of 4 bytes each, MSB first, then CHK. CHK is the XOR of N and all data bytes.
- **Loader FSM**
  - IDLE:
    - Byte `0xA5` → CNT. On entry: `busy`=1, `cpu_rst_n`=0, `done`=0, `err`=0, address=0, running XOR=0.
    - Other bytes and `rx_ferr` are ignored.
  - CNT: byte → DATA. Store N, XOR in N, clear the byte index.
  - DATA:
    - Each byte shifts into the 32-bit word and is XORed into the checksum.
    - On the 4th byte: `mem_we`=1 for one cycle with the current address and word; address increments (mod 2^ADDR_W); words remaining decrements.
    - After the last word → CHK.
  - CHK:
    - Byte == XOR → DONE.
    - Byte != XOR → ERR.
  - DONE (1 cycle): `done`=1, `busy`=0, `cpu_rst_n`=1 → IDLE.
  - ERR (1 cycle): `err`=1, `busy`=0; `cpu_rst_n` stays 0 → IDLE.
- **Abort conditions**
  - In CNT, DATA or CHK, `rx_ferr` → ERR.
  - In CNT, DATA or CHK, a gap of `TIMEOUT_CYC` cycles since the last byte → ERR. The timeout counter reloads on every `rx_valid`.
- Words already written before an abort remain in memory. The CPU stays in reset until a subsequent frame verifies.
- A `0xA5` byte inside a frame is treated as data, not as a resynchronization marker.
- If N exceeds 2^ADDR_W, the address wraps and earlier words are overwritten. This is legal.

## Timing
- **Reset values:** `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_rst_n`=1 (the CPU runs its built-in image), `busy`=0, `done`=0, `err`=0. Receiver and FSM are in idle.
- **Reset mid-frame:** a synchronous reset mid-frame restores all reset values on the next edge. `cpu_rst_n` therefore returns to 1.
- **Byte latency:** `rx_valid` rises about 9.5 bit times after the start-bit falling edge, plus 2 cycles of synchronizer delay.
- **Write timing:**
  - `mem_we` asserts the cycle after the `rx_valid` of each word's 4th byte.
  - `mem_addr` and `mem_wdata` are valid while `mem_we`=1 and hold their values afterwards.
- **Release timing:**
  - `cpu_rst_n` rises 2 cycles after the `rx_valid` of the CHK byte.
  - `done` rises on the same edge.
- **Registered outputs:** all outputs are registered; there are no combinational paths from `uart_rx`.
- **Back-to-back bytes** (stop bit immediately followed by a start bit) must be received without loss.
- **Back-to-back frames:** a new `0xA5` may arrive on the cycle after DONE or ERR returns to IDLE.

## Test plan
Benches use `CLKS_PER_BIT`=8 and `TIMEOUT_CYC`=400.

1. **Reset:** hold `rst_n`=0 for 3 edges → all outputs at the reset values above, with `cpu_rst_n`=1.
2. **Two-word load:** send A5 02 28 00 00 01 28 00 00 02 01.
   - Required: `mem_we` at addr 0 with data 0x28000001, then at addr 1 with data 0x28000002.
   - Then `done`=1, `err`=0, `cpu_rst_n`=1, `busy`=0.
3. **Bad checksum:** send the same frame with CHK=0x00.
   - Required: both writes still occur.
   - Then `err`=1, `done`=0, and `cpu_rst_n` stays 0.
   - A correct frame sent afterwards → `done`=1, `err`=0, `cpu_rst_n`=1.
4. **Timeout:** send A5 01 28 00, then leave the line idle for 500 cycles.
   - Required: no `mem_we`; `err`=1 at timeout; `cpu_rst_n`=0.
   - A later byte 0x00 is ignored in IDLE.
5. **Framing and glitch:**
   - A 2-cycle low glitch in IDLE → no byte is received.
   - A byte with stop bit 0 sent after A5 → `err`=1.
6. **Wrap, N=0, and reset mid-frame:**
   - N=0 with `ADDR_W`=4 → 256 writes; addresses cycle 0–15 sixteen times; correct CHK → `done`=1.
   - Repeat the frame and assert `rst_n` after the 10th word → next edge: `cpu_rst_n`=1, `busy`=0, `done`=0.
